run_length_decoder: RTL and testbench
=====================================

RUN_LENGTH_DECODER -- requirements
Module: run_length_decoder

Interface
REQ-001 SHALL have parameter J_length, default 5, width of J table entries and of the remainder bit counter.
REQ-002 SHALL have parameter runcount_length, default 16, width of run counts and pixel counts.
REQ-003 SHALL have parameter runindex_length, default 5, width of RUNindex (range 0..31).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port scan_start  input  1  pulse; clears RUNindex to 0 and aborts any run in progress.
REQ-007 SHALL have port start  input  1  pulse; begins decoding one run.
REQ-008 SHALL have port pixels_left  input  runcount_length  pixels from the current position to end of line; sampled when start is accepted.
REQ-009 SHALL have port bit_in  input  1  next coded bitstream bit.
REQ-010 SHALL have port bit_valid  input  1  bit_in is valid.
REQ-011 SHALL have port bit_ready  output  1  decoder consumes bit_in this cycle.
REQ-012 SHALL have port run_length  output  runcount_length  decoded run length.
REQ-013 SHALL have port run_valid  output  1  one-cycle pulse qualifying run_length, run_eol and run_err.
REQ-014 SHALL have port run_eol  output  1  run ended at end of line, with no interruption sample following.
REQ-015 SHALL have port run_err  output  1  decoded remainder overran the line.
REQ-016 SHALL have port run_index  output  runindex_length  current RUNindex.
REQ-017 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-018 SHALL hold an internal 32-entry J ROM: 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15.
REQ-019 SHALL implement the states IDLE, READ_FLAG, READ_REM and DONE.
REQ-020 SHALL, in IDLE with start=1, latch pixels_left into rem_px and clear count; the next state SHALL be DONE if pixels_left==0, else READ_FLAG.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL consume a bit only on a rising edge where bit_valid and bit_ready are both 1; bit_ready SHALL be 1 only in READ_FLAG and READ_REM.
REQ-023 SHALL, in READ_FLAG on a consumed 1: set seg = 1<<J[RUNindex]; count += min(seg, rem_px-count).
REQ-024 SHALL, on that 1 bit when the full seg was added and RUNindex<31, increment RUNindex.
REQ-025 SHALL, on that 1 bit, go to DONE with eol=1 if the new count == rem_px, else stay in READ_FLAG.
REQ-026 SHALL, in READ_FLAG on a consumed 0, go to DONE with eol=0 if J[RUNindex]==0, else go to READ_REM with a bit counter of J[RUNindex].
REQ-027 SHALL, in READ_REM, shift J[RUNindex] bits MSB-first into rem, then set count += rem and go to DONE with eol=0.
REQ-028 SHALL, if count+rem >= rem_px, set err=1 and saturate count to rem_px-1.
REQ-029 SHALL perform the comparisons of REQ-023 to REQ-028 at runcount_length+1 bits, so that no overflow occurs.
REQ-030 SHALL, in DONE, register run_length=count, run_eol=eol and run_err=err, pulse run_valid for exactly one cycle, and return to IDLE.
REQ-031 SHALL, at the DONE transition when eol=0, decrement RUNindex if it is >0; eol=1 SHALL leave RUNindex unchanged by this rule.
REQ-032 SHALL hold all state and shift registers while bit_valid=0, with no timeout.
REQ-033 SHALL, on scan_start, force IDLE and RUNindex=0 on the next edge, produce no run_valid, and take priority over start in the same cycle.
REQ-034 SHALL make run_length, run_eol and run_err hold their values between run_valid pulses.

Reset
REQ-035 SHALL, while reset=0 (asynchronous), force state=IDLE, RUNindex=0, count=0, and all outputs to 0, including bit_ready, run_valid and busy.
REQ-036 SHALL, on reset assertion mid-run, discard the run and emit no run_valid.

Verification
REQ-037 SHALL be checked by: RUNindex=0, pixels_left=10, bits 1,1,0 -> run_length=2, eol=0, RUNindex 0->1->2, then 1 after DONE.
REQ-038 SHALL be checked by: RUNindex=0, pixels_left=3, bits 1,1,1 -> run_length=3, eol=1, RUNindex=3, exactly 3 bits consumed, bit_ready low afterwards.
REQ-039 SHALL be checked by: following REQ-038, pixels_left=20, bits 1,1,0,1 -> count 1 (RUNindex 4), then 3 (RUNindex 5), then remainder 1 -> run_length=4, eol=0, RUNindex=4.
REQ-040 SHALL be checked by: start with pixels_left=0 -> run_valid on the second cycle, run_length=0, eol=1, bit_ready never high.
REQ-041 SHALL be checked by: RUNindex=4, pixels_left=1, bits 0,1 -> run_err=1, run_length=0; and separately, bit_valid held low for 5 cycles mid-run -> no state change.
REQ-042 SHALL be checked by: reset pulsed low in READ_REM -> busy=0 and RUNindex=0 immediately, no run_valid; and scan_start with start in the same cycle -> IDLE, RUNindex=0.

Source files
------------

// File: rtl/run_length_decoder_if.sv
// Bundles the run-length decoder control, bitstream and result signals.
// The master side drives run requests and bits; the slave side is the decoder.
interface run_length_decoder_if #(
  parameter int unsigned runcount_length = 16,
  parameter int unsigned runindex_length = 5
);
  logic                       scan_start;
  logic                       start;
  logic [runcount_length-1:0] pixels_left;
  logic                       bit_in;
  logic                       bit_valid;
  logic                       bit_ready;
  logic [runcount_length-1:0] run_length;
  logic                       run_valid;
  logic                       run_eol;
  logic                       run_err;
  logic [runindex_length-1:0] run_index;
  logic                       busy;

  modport master (
    output scan_start, start, pixels_left, bit_in, bit_valid,
    input  bit_ready, run_length, run_valid, run_eol, run_err, run_index, busy
  );

  modport slave (
    input  scan_start, start, pixels_left, bit_in, bit_valid,
    output bit_ready, run_length, run_valid, run_eol, run_err, run_index, busy
  );
endinterface

// File: rtl/run_length_decoder.sv
// Run-length decoder: decodes one run per start request from an adaptive
// bitstream. Each '1' flag adds a 2^J[RUNindex] segment (clipped to the end of
// line); a '0' flag terminates the run with a J[RUNindex]-bit remainder.
// RUNindex adapts upward on full segments and downward on interrupted runs.
module run_length_decoder #(
  parameter int unsigned J_length        = 5,
  parameter int unsigned runcount_length = 16,
  parameter int unsigned runindex_length = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  run_length_decoder_if.slave  bus
);

  localparam int unsigned W1 = runcount_length + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ_FLAG,
    READ_REM,
    DONE
  } state_t;

  state_t                     state;
  logic [runcount_length-1:0] rem_px;
  logic [runcount_length-1:0] count;
  logic [runcount_length-1:0] rem;
  logic [J_length-1:0]        bit_cnt;
  logic [runindex_length-1:0] run_idx;
  logic                       eol;
  logic                       err;

  logic                       bit_ready_q;
  logic                       busy_q;
  logic                       run_valid_q;
  logic [runcount_length-1:0] run_length_q;
  logic                       run_eol_q;
  logic                       run_err_q;

  logic [J_length-1:0]        j_cur;
  logic [W1-1:0]              seg;
  logic [W1-1:0]              diff;
  logic                       seg_full;
  logic [W1-1:0]              flag_sum;
  logic [runcount_length-1:0] rem_next;
  logic [W1-1:0]              rem_sum;
  logic                       rem_over;
  logic                       consume;

  // 32-entry J table indexed by RUNindex
  function automatic logic [J_length-1:0] j_rom(input logic [runindex_length-1:0] idx);
    logic [4:0] i5;
    logic [4:0] j5;
    i5 = 5'(idx);
    case (i5)
      5'd0,  5'd1,  5'd2,  5'd3:  j5 = 5'd0;
      5'd4,  5'd5,  5'd6,  5'd7:  j5 = 5'd1;
      5'd8,  5'd9,  5'd10, 5'd11: j5 = 5'd2;
      5'd12, 5'd13, 5'd14, 5'd15: j5 = 5'd3;
      5'd16, 5'd17:               j5 = 5'd4;
      5'd18, 5'd19:               j5 = 5'd5;
      5'd20, 5'd21:               j5 = 5'd6;
      5'd22, 5'd23:               j5 = 5'd7;
      5'd24:                      j5 = 5'd8;
      5'd25:                      j5 = 5'd9;
      5'd26:                      j5 = 5'd10;
      5'd27:                      j5 = 5'd11;
      5'd28:                      j5 = 5'd12;
      5'd29:                      j5 = 5'd13;
      5'd30:                      j5 = 5'd14;
      default:                    j5 = 5'd15;
    endcase
    return J_length'(j5);
  endfunction

  // Segment/remainder arithmetic, one bit wider than the counts to avoid overflow
  always_comb begin
    j_cur    = j_rom(run_idx);
    seg      = W1'(1) << j_cur;
    diff     = {1'b0, rem_px} - {1'b0, count};
    seg_full = (seg <= diff);
    flag_sum = {1'b0, count} + (seg_full ? seg : diff);
    rem_next = {rem[runcount_length-2:0], bus.bit_in};
    rem_sum  = {1'b0, count} + {1'b0, rem_next};
    rem_over = (rem_sum >= {1'b0, rem_px});
    consume  = bus.bit_valid & bit_ready_q;
  end

  // Decoder FSM with registered outputs; scan_start overrides everything but reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rem_px       <= '0;
      count        <= '0;
      rem          <= '0;
      bit_cnt      <= '0;
      run_idx      <= '0;
      eol          <= 1'b0;
      err          <= 1'b0;
      bit_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      run_valid_q  <= 1'b0;
      run_length_q <= '0;
      run_eol_q    <= 1'b0;
      run_err_q    <= 1'b0;
    end else if (bus.scan_start) begin
      state       <= IDLE;
      run_idx     <= '0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      run_valid_q <= 1'b0;
    end else begin
      run_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem_px <= bus.pixels_left;
            count  <= '0;
            err    <= 1'b0;
            busy_q <= 1'b1;
            if (bus.pixels_left == '0) begin
              eol         <= 1'b1;
              bit_ready_q <= 1'b0;
              state       <= DONE;
            end else begin
              eol         <= 1'b0;
              bit_ready_q <= 1'b1;
              state       <= READ_FLAG;
            end
          end
        end
        READ_FLAG: begin
          if (consume) begin
            if (bus.bit_in) begin
              count <= flag_sum[runcount_length-1:0];
              if (seg_full && (run_idx != '1))
                run_idx <= run_idx + 1'b1;
              if (flag_sum == {1'b0, rem_px}) begin
                eol         <= 1'b1;
                bit_ready_q <= 1'b0;
                state       <= DONE;
              end
            end else if (j_cur == '0) begin
              eol         <= 1'b0;
              bit_ready_q <= 1'b0;
              state       <= DONE;
              if (run_idx != '0)
                run_idx <= run_idx - 1'b1;
            end else begin
              bit_cnt <= j_cur;
              rem     <= '0;
              state   <= READ_REM;
            end
          end
        end
        READ_REM: begin
          if (consume) begin
            rem     <= rem_next;
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == J_length'(1)) begin
              count       <= rem_over ? (rem_px - 1'b1) : rem_sum[runcount_length-1:0];
              err         <= rem_over;
              eol         <= 1'b0;
              bit_ready_q <= 1'b0;
              state       <= DONE;
              if (run_idx != '0)
                run_idx <= run_idx - 1'b1;
            end
          end
        end
        DONE: begin
          run_length_q <= count;
          run_eol_q    <= eol;
          run_err_q    <= err;
          run_valid_q  <= 1'b1;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state       <= IDLE;
          bit_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_ready  = bit_ready_q;
  assign bus.busy       = busy_q;
  assign bus.run_valid  = run_valid_q;
  assign bus.run_length = run_length_q;
  assign bus.run_eol    = run_eol_q;
  assign bus.run_err    = run_err_q;
  assign bus.run_index  = run_idx;

endmodule

// File: tb/tb_run_length_decoder.sv
// Testbench for run_length_decoder: scenario tasks push expected runs into a
// scoreboard; a negedge monitor pops and compares on every run_valid.
module tb_run_length_decoder;

  localparam int unsigned RC = 16;
  localparam int unsigned RI = 5;

  typedef struct {
    logic [RC-1:0] len;
    logic          eol;
    logic          err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  run_length_decoder_if #(.runcount_length(RC), .runindex_length(RI)) bus ();

  run_length_decoder #(
    .J_length(5),
    .runcount_length(RC),
    .runindex_length(RI)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t sb[$];
  int   tests_run  = 0;
  int   failures   = 0;
  int   runs_seen  = 0;
  int   runs_exp   = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.run_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_run_valid: got len=%0d eol=%0b err=%0b, required no run",
                 bus.run_length, bus.run_eol, bus.run_err);
      end else begin
        e = sb.pop_front();
        if ({bus.run_length, bus.run_eol, bus.run_err} !== {e.len, e.eol, e.err}) begin
          failures++;
          $display("FAIL run_result: got len=%0d eol=%0b err=%0b, required len=%0d eol=%0b err=%0b",
                   bus.run_length, bus.run_eol, bus.run_err, e.len, e.eol, e.err);
        end
      end
      runs_seen++;
      if (prev_valid) begin
        tests_run++;
        failures++;
        $display("FAIL run_valid_width: got 2+ cycle pulse, required 1 cycle");
      end
    end
    prev_valid = bus.run_valid;
  end

  task automatic push_exp(input int len, input logic eol, input logic err);
    exp_t e;
    e.len = RC'(len);
    e.eol = eol;
    e.err = err;
    sb.push_back(e);
    runs_exp++;
  endtask

  task automatic start_run(input int pl);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.pixels_left = RC'(pl);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int i;
    @(negedge clk);
    i = 0;
    while (!bus.bit_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!bus.bit_ready) begin
      tests_run++;
      failures++;
      $display("FAIL bit_ready_timeout: got bit_ready=0, required 1");
    end
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic wait_runs();
    for (int i = 0; i < 40 && runs_seen < runs_exp; i++) begin
      @(negedge clk);
      #1;
    end
    tests_run++;
    if (runs_seen < runs_exp) begin
      failures++;
      $display("FAIL run_timeout: got %0d runs, required %0d", runs_seen, runs_exp);
    end
  endtask

  task automatic scan();
    @(negedge clk);
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
  endtask

  task automatic test_reset();
    bus.scan_start  = 1'b0;
    bus.start       = 1'b0;
    bus.pixels_left = '0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.bit_ready, bus.run_valid, bus.run_eol, bus.run_err,
         bus.run_index, bus.run_length} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%0b rdy=%0b vld=%0b eol=%0b err=%0b idx=%0d len=%0d, required all 0",
               bus.busy, bus.bit_ready, bus.run_valid, bus.run_eol, bus.run_err,
               bus.run_index, bus.run_length);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    scan();
    tests_run++;
    if (bus.run_index !== 5'd0) begin
      failures++;
      $display("FAIL basic_idx0: got %0d, required 0", bus.run_index);
    end
    push_exp(2, 1'b0, 1'b0);
    start_run(10);
    send_bit(1'b1);
    tests_run++;
    if (bus.run_index !== 5'd1) begin
      failures++;
      $display("FAIL basic_idx1: got %0d, required 1", bus.run_index);
    end
    send_bit(1'b1);
    tests_run++;
    if (bus.run_index !== 5'd2) begin
      failures++;
      $display("FAIL basic_idx2: got %0d, required 2", bus.run_index);
    end
    send_bit(1'b0);
    tests_run++;
    if (bus.run_index !== 5'd1) begin
      failures++;
      $display("FAIL basic_idx_done: got %0d, required 1", bus.run_index);
    end
    wait_runs();
  endtask

  task automatic test_eol();
    scan();
    push_exp(3, 1'b1, 1'b0);
    start_run(3);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_runs();
    tests_run++;
    if (bus.run_index !== 5'd3) begin
      failures++;
      $display("FAIL eol_idx: got %0d, required 3", bus.run_index);
    end
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if (bus.bit_ready !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL eol_extra_bit: got bit_ready=%0b busy=%0b, required 0 0",
                 bus.bit_ready, bus.busy);
      end
    end
    bus.bit_valid = 1'b0;
    tests_run++;
    if (bus.run_index !== 5'd3) begin
      failures++;
      $display("FAIL eol_idx_hold: got %0d, required 3", bus.run_index);
    end
  endtask

  task automatic test_remainder();
    push_exp(4, 1'b0, 1'b0);
    start_run(20);
    send_bit(1'b1);
    tests_run++;
    if (bus.run_index !== 5'd4) begin
      failures++;
      $display("FAIL rem_idx4: got %0d, required 4", bus.run_index);
    end
    send_bit(1'b1);
    tests_run++;
    if (bus.run_index !== 5'd5) begin
      failures++;
      $display("FAIL rem_idx5: got %0d, required 5", bus.run_index);
    end
    send_bit(1'b0);
    tests_run++;
    if (bus.bit_ready !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rem_in_read_rem: got bit_ready=%0b busy=%0b, required 1 1",
               bus.bit_ready, bus.busy);
    end
    send_bit(1'b1);
    tests_run++;
    if (bus.run_index !== 5'd4) begin
      failures++;
      $display("FAIL rem_idx_done: got %0d, required 4", bus.run_index);
    end
    wait_runs();
  endtask

  task automatic test_err();
    push_exp(0, 1'b0, 1'b1);
    start_run(1);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_runs();
    tests_run++;
    if (bus.run_index !== 5'd3) begin
      failures++;
      $display("FAIL err_idx: got %0d, required 3", bus.run_index);
    end
  endtask

  task automatic test_stall();
    push_exp(2, 1'b0, 1'b0);
    start_run(20);
    send_bit(1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        bus.bit_in = ~bus.bit_in;
        // start outside IDLE must be ignored
        bus.start       = (c == 2);
        bus.pixels_left = RC'(1);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.bit_ready !== 1'b1 ||
            bus.run_index !== 5'd4 || bus.run_valid !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold: got busy=%0b rdy=%0b idx=%0d vld=%0b, required 1 1 4 0",
                   bus.busy, bus.bit_ready, bus.run_index, bus.run_valid);
        end
      end
      bus.start = 1'b0;
      if (pass == 0) send_bit(1'b0);
    end
    send_bit(1'b1);
    wait_runs();
    tests_run++;
    if (bus.run_index !== 5'd3) begin
      failures++;
      $display("FAIL stall_idx: got %0d, required 3", bus.run_index);
    end
  endtask

  task automatic test_zero();
    push_exp(0, 1'b1, 1'b0);
    start_run(0);
    #1;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.bit_ready !== 1'b0 || bus.run_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_cycle1: got busy=%0b rdy=%0b vld=%0b, required 1 0 0",
               bus.busy, bus.bit_ready, bus.run_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.run_valid !== 1'b1 || bus.bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_cycle2: got vld=%0b rdy=%0b, required 1 0", bus.run_valid, bus.bit_ready);
    end
    wait_runs();
    tests_run++;
    if (bus.run_index !== 5'd3) begin
      failures++;
      $display("FAIL zero_idx: got %0d, required 3", bus.run_index);
    end
  endtask

  task automatic test_back_to_back();
    scan();
    push_exp(2, 1'b1, 1'b0);
    start_run(2);
    send_bit(1'b1);
    send_bit(1'b1);
    wait_runs();
    bus.start       = 1'b1;
    bus.pixels_left = RC'(5);
    push_exp(0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    send_bit(1'b0);
    wait_runs();
    tests_run++;
    if (bus.run_index !== 5'd1) begin
      failures++;
      $display("FAIL b2b_idx: got %0d, required 1", bus.run_index);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.run_length, bus.run_eol, bus.run_err} !== {RC'(0), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_hold: got len=%0d eol=%0b err=%0b, required 0 0 0",
               bus.run_length, bus.run_eol, bus.run_err);
    end
  endtask

  task automatic test_reset_mid();
    start_run(20);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    tests_run++;
    if (bus.bit_ready !== 1'b1 || bus.run_index !== 5'd4) begin
      failures++;
      $display("FAIL rstmid_pre: got rdy=%0b idx=%0d, required 1 4", bus.bit_ready, bus.run_index);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.run_index !== 5'd0 || bus.bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: got busy=%0b idx=%0d rdy=%0b, required 0 0 0",
               bus.busy, bus.run_index, bus.bit_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle: got busy=%0b, required 0", bus.busy);
    end
  endtask

  task automatic test_scan_start();
    start_run(20);
    send_bit(1'b1);
    send_bit(1'b1);
    tests_run++;
    if (bus.run_index !== 5'd2 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL scan_pre: got idx=%0d busy=%0b, required 2 1", bus.run_index, bus.busy);
    end
    @(negedge clk);
    bus.scan_start  = 1'b1;
    bus.start       = 1'b1;
    bus.pixels_left = RC'(5);
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.run_index !== 5'd0 || bus.bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL scan_priority: got busy=%0b idx=%0d rdy=%0b, required 0 0 0",
               bus.busy, bus.run_index, bus.bit_ready);
    end
    @(negedge clk);
    bus.scan_start = 1'b0;
    bus.start      = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL scan_idle: got busy=%0b, required 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eol();
    test_remainder();
    test_err();
    test_stall();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_scan_start();
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending runs, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
